// File: rtl/key_reset_conditioner.sv
// Debounces four active-low push-buttons, emits press events, and turns the
// KEY0+KEY1 / KEY2+KEY3 chords into fixed-length reset pulses. Optional: KEYCOND_HOLD_TIMER_EN.
module key_reset_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES        = 25000000,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] key_db,
  output logic [3:0] key_press,
  output logic       sys_reset,
  output logic       gb_reset,
  output logic [1:0] chord_busy
);

  localparam int unsigned NKEYS   = 4;
  localparam int unsigned NCHORDS = 2;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
`ifdef KEYCOND_HOLD_TIMER_EN
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`endif

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || RESET_PULSE_CYCLES < 1) begin : g_param_check
    $error("key_reset_conditioner: parameter out of legal range");
  end

`ifdef KEYCOND_HOLD_TIMER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, FIRE = 2'd2, WAIT_REL = 2'd3} chord_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd2, WAIT_REL = 2'd3} chord_state_e;
`endif

  logic [NKEYS-1:0]   sync1;
  logic [NKEYS-1:0]   sync2;
  logic [DW-1:0]      db_cnt [NKEYS];
  logic [NCHORDS-1:0] fire_next;
  logic [NCHORDS-1:0] busy_next;

  // Two-flop synchroniser on the raw level, then a per-key stability counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= '1;
      sync2     <= '1;
      key_db    <= '0;
      key_press <= '0;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int i = 0; i < NKEYS; i++) begin
        key_press[i] <= 1'b0;
        if (~sync2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i]    <= '0;
          key_db[i]    <= ~key_db[i];
          key_press[i] <= ~key_db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < NCHORDS; c++) begin : g_chord
    logic          both;
    logic          any;
    chord_state_e  state;
    chord_state_e  state_next;
    logic [PW-1:0] pulse_cnt;
    logic [PW-1:0] pulse_cnt_next;
`ifdef KEYCOND_HOLD_TIMER_EN
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_next;
`endif

    assign both = key_db[2*c] & key_db[2*c+1];
    assign any  = key_db[2*c] | key_db[2*c+1];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state     <= IDLE;
        pulse_cnt <= '0;
`ifdef KEYCOND_HOLD_TIMER_EN
        hold_cnt  <= '0;
`endif
      end else begin
        state     <= state_next;
        pulse_cnt <= pulse_cnt_next;
`ifdef KEYCOND_HOLD_TIMER_EN
        hold_cnt  <= hold_cnt_next;
`endif
      end
    end

    // Once FIRE is entered the pulse always runs to completion; re-arm needs a full release.
    always_comb begin
      state_next     = state;
      pulse_cnt_next = pulse_cnt;
`ifdef KEYCOND_HOLD_TIMER_EN
      hold_cnt_next  = hold_cnt;
`endif
      case (state)
        IDLE: begin
          if (both) begin
`ifdef KEYCOND_HOLD_TIMER_EN
            hold_cnt_next  = '0;
            state_next     = ARM;
`else
            pulse_cnt_next = '0;
            state_next     = FIRE;
`endif
          end
        end
`ifdef KEYCOND_HOLD_TIMER_EN
        ARM: begin
          if (!both) begin
            state_next = IDLE;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            pulse_cnt_next = '0;
            state_next     = FIRE;
          end else begin
            hold_cnt_next = hold_cnt + HW'(1);
          end
        end
`endif
        FIRE: begin
          if (pulse_cnt == PW'(RESET_PULSE_CYCLES - 1)) begin
            state_next = WAIT_REL;
          end else begin
            pulse_cnt_next = pulse_cnt + PW'(1);
          end
        end
        WAIT_REL: begin
          if (!any) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    assign fire_next[c] = (state_next == FIRE);
    assign busy_next[c] = (state_next != IDLE);
  end

  // A system reset also resets the Game Boy core, so gb_reset is the union of both pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sys_reset  <= 1'b0;
      gb_reset   <= 1'b0;
      chord_busy <= '0;
    end else begin
      sys_reset  <= fire_next[0];
      gb_reset   <= |fire_next;
      chord_busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_key_reset_conditioner.sv
// Self-checking bench for key_reset_conditioner: debounce vector table plus
// chord/reset sequences with an expected-pulse scoreboard.
module tb_key_reset_conditioner;

  localparam int unsigned DB    = 8;
  localparam int unsigned HOLD  = 32;
  localparam int unsigned PULSE = 4;
`ifdef KEYCOND_HOLD_TIMER_EN
  localparam int HE = HOLD;
`else
  localparam int HE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] key_db;
  logic [3:0] key_press;
  logic       sys_reset;
  logic       gb_reset;
  logic [1:0] chord_busy;

  key_reset_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .RESET_PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n(key_n),
    .key_db(key_db),
    .key_press(key_press),
    .sys_reset(sys_reset),
    .gb_reset(gb_reset),
    .chord_busy(chord_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int start; int len; } pulse_t;
  typedef struct { logic [3:0] key_n; int hold; logic [3:0] db; logic [3:0] press; } vec_t;

  pulse_t exp_sys[$];
  pulse_t exp_gb[$];
  pulse_t obs_sys[$];
  pulse_t obs_gb[$];

  int         checks = 0;
  int         errors = 0;
  int         press_cnt [4] = '{default: 0};
  int         bad_press = 0;
  logic [3:0] prev_db = '0;
  logic       prev_sys = 1'b0;
  logic       prev_gb = 1'b0;
  int         sys_start = 0, sys_len = 0, gb_start = 0, gb_len = 0;
  pulse_t     mp;

  // Monitor: counts press events and records every reset pulse as {start edge, length}.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (key_press[i]) begin
        press_cnt[i]++;
        if (!key_db[i] || prev_db[i]) bad_press++;
      end
    end
    prev_db = key_db;
    if (sys_reset && !prev_sys) begin sys_start = cyc; sys_len = 0; end
    if (sys_reset) sys_len++;
    if (!sys_reset && prev_sys) begin mp.start = sys_start; mp.len = sys_len; obs_sys.push_back(mp); end
    prev_sys = sys_reset;
    if (gb_reset && !prev_gb) begin gb_start = cyc; gb_len = 0; end
    if (gb_reset) gb_len++;
    if (!gb_reset && prev_gb) begin mp.start = gb_start; mp.len = gb_len; obs_gb.push_back(mp); end
    prev_gb = gb_reset;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_pulse(input bit sys, input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    if (sys) exp_sys.push_back(p);
    else     exp_gb.push_back(p);
  endtask

  task automatic check_pulses(input string name);
    pulse_t e, o;
    check({name, " sys pulse count"}, obs_sys.size(), exp_sys.size());
    while (exp_sys.size() > 0 && obs_sys.size() > 0) begin
      e = exp_sys.pop_front();
      o = obs_sys.pop_front();
      check({name, " sys start"}, o.start, e.start);
      check({name, " sys length"}, o.len, e.len);
    end
    check({name, " gb pulse count"}, obs_gb.size(), exp_gb.size());
    while (exp_gb.size() > 0 && obs_gb.size() > 0) begin
      e = exp_gb.pop_front();
      o = obs_gb.pop_front();
      check({name, " gb start"}, o.start, e.start);
      check({name, " gb length"}, o.len, e.len);
    end
    exp_sys.delete(); obs_sys.delete();
    exp_gb.delete();  obs_gb.delete();
  endtask

  task automatic release_all(input int settle);
    key_n = 4'b1111;
    wait_cyc(cyc + settle);
  endtask

  vec_t vecs [9];
  int   base [4];
  int   t0, t1, s;
  logic seen;

  initial begin
    vecs[0] = '{4'b1110, 9,  4'b0000, 4'b0000};
    vecs[1] = '{4'b1110, 1,  4'b0001, 4'b0001};
    vecs[2] = '{4'b1111, 10, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1011, 10, 4'b0100, 4'b0100};
    vecs[4] = '{4'b1010, 10, 4'b0101, 4'b0001};
    vecs[5] = '{4'b1111, 10, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0111, 10, 4'b1000, 4'b1000};
    vecs[7] = '{4'b1101, 10, 4'b0010, 4'b0010};
    vecs[8] = '{4'b1111, 10, 4'b0000, 4'b0000};

    reset_n = 1'b0;
    key_n   = 4'b1111;
    wait_cyc(3);
    check("reset key_db", int'(key_db), 0);
    check("reset key_press", int'(key_press), 0);
    check("reset sys_reset", int'(sys_reset), 0);
    check("reset gb_reset", int'(gb_reset), 0);
    check("reset chord_busy", int'(chord_busy), 0);
    reset_n = 1'b1;
    wait_cyc(cyc + 5);

    // Bouncing key 0: runs of 3 cycles never reach the debounce count.
    base = press_cnt;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) key_n[0] = ~key_n[0];
      wait_cyc(cyc + 1);
      seen |= key_db[0];
    end
    key_n[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      wait_cyc(cyc + 1);
      seen |= key_db[0];
    end
    check("bounce key_db0 ever set", int'(seen), 0);
    check("bounce press count", press_cnt[0] - base[0], 0);

    for (int v = 0; v < 9; v++) begin
      base  = press_cnt;
      key_n = vecs[v].key_n;
      wait_cyc(cyc + vecs[v].hold);
      check($sformatf("vec%0d key_db", v), int'(key_db), int'(vecs[v].db));
      for (int i = 0; i < 4; i++)
        check($sformatf("vec%0d press[%0d]", v, i), press_cnt[i] - base[i], int'(vecs[v].press[i]));
    end
    check("table no pulses", obs_sys.size() + obs_gb.size(), 0);
    wait_cyc(cyc + 5);

    // Game Boy chord: one pulse per hold, re-fire only after full release.
    base = press_cnt;
    t0 = cyc;
    key_n = 4'b0011;
    push_pulse(1'b0, t0 + 11 + HE, PULSE);
    wait_cyc(t0 + 9);
    check("gb chord key_db before latency", int'(key_db), 0);
    wait_cyc(t0 + 10);
    check("gb chord key_db at latency", int'(key_db), 4'b1100);
    wait_cyc(t0 + 100);
    check("gb chord sys_reset", int'(sys_reset), 0);
    check("gb chord busy while held", int'(chord_busy), 2'b10);
    key_n = 4'b1111;
    wait_cyc(t0 + 115);
    check("gb chord busy after release", int'(chord_busy), 0);
    t1 = cyc;
    key_n = 4'b0011;
    push_pulse(1'b0, t1 + 11 + HE, PULSE);
    wait_cyc(t1 + 60);
    release_all(15);
    check_pulses("gb chord");
    check("gb chord press[2]", press_cnt[2] - base[2], 2);
    check("gb chord press[3]", press_cnt[3] - base[3], 2);

`ifdef KEYCOND_HOLD_TIMER_EN
    // System chord aborted during ARM by releasing key 1.
    t0 = cyc;
    key_n = 4'b1100;
    wait_cyc(t0 + 20);
    check("sys chord busy in ARM", int'(chord_busy), 2'b01);
    wait_cyc(t0 + 31);
    key_n = 4'b1110;
    wait_cyc(t0 + 42);
    check("sys chord busy after abort", int'(chord_busy), 0);
    wait_cyc(t0 + 50);
    check_pulses("sys chord abort");
`endif
    t1 = cyc;
    key_n = 4'b1100;
    push_pulse(1'b1, t1 + 11 + HE, PULSE);
    push_pulse(1'b0, t1 + 11 + HE, PULSE);
    wait_cyc(t1 + 60);
    release_all(15);
    check_pulses("sys chord");

    // All four keys at once: coincident fires, one merged gb pulse.
    t0 = cyc;
    key_n = 4'b0000;
    push_pulse(1'b1, t0 + 11 + HE, PULSE);
    push_pulse(1'b0, t0 + 11 + HE, PULSE);
    wait_cyc(t0 + 60);
    check("all keys busy", int'(chord_busy), 2'b11);
    release_all(15);
    check_pulses("coincident");

    // Staggered chords: gb pulse spans the union of both pulses.
    t0 = cyc;
    key_n = 4'b0011;
    wait_cyc(t0 + 2);
    key_n = 4'b0000;
    push_pulse(1'b0, t0 + 11 + HE, PULSE + 2);
    push_pulse(1'b1, t0 + 13 + HE, PULSE);
    wait_cyc(t0 + 60);
    release_all(15);
    check_pulses("overlap");

    // Reset during the second cycle of a gb pulse, keys held throughout.
    base = press_cnt;
    t0 = cyc;
    key_n = 4'b0011;
    s = t0 + 11 + HE;
    push_pulse(1'b0, s, 2);
    wait_cyc(s);
    check("mid reset gb pulse started", int'(gb_reset), 1);
    wait_cyc(s + 1);
    reset_n = 1'b0;
    wait_cyc(s + 2);
    check("mid reset gb cut off", int'(gb_reset), 0);
    check("mid reset key_db cleared", int'(key_db), 0);
    check("mid reset busy cleared", int'(chord_busy), 0);
    reset_n = 1'b1;
    wait_cyc(s + 11);
    check("post reset key_db before latency", int'(key_db), 0);
    wait_cyc(s + 12);
    check("post reset key_db at latency", int'(key_db), 4'b1100);
    push_pulse(1'b0, s + 13 + HE, PULSE);
    wait_cyc(s + 60);
    release_all(15);
    check_pulses("mid reset");
    check("mid reset press[2]", press_cnt[2] - base[2], 2);
    check("mid reset press[3]", press_cnt[3] - base[3], 2);

    check("press only on debounced rise", bad_press, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
